// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and types for the ALU command-issue stage.
// Optional feature macro used by this slice: ALU_ISSUE_ERR_EN.
package alu_issue_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_ADD        = 3'd0;
  localparam logic [OPC_W-1:0] OP_SUB        = 3'd1;
  localparam logic [OPC_W-1:0] OP_MUL        = 3'd2;
  localparam logic [OPC_W-1:0] OP_NOR        = 3'd3;
  localparam logic [OPC_W-1:0] OP_NAND       = 3'd4;
  localparam logic [OPC_W-1:0] OP_LAST_LEGAL = 3'd4;

  // IDLE: nothing held; EXEC: operands drive the ALU; HOLD: result offered downstream
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    return (op <= OP_LAST_LEGAL);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle between upstream producer, issue stage, ALU and downstream consumer.
// Optional feature macro used by this slice: ALU_ISSUE_ERR_EN.
//
// Handshake rule for both in_* and out_* channels: a transfer happens on the
// rising edge where valid && ready are both 1. A producer holding valid keeps
// its payload stable until the transfer; ready never depends combinationally
// on the other channel's ready.
interface alu_issue_if #(parameter int WIDTH = 4);
  import alu_issue_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [OPC_W-1:0]       in_control;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;

  logic [OPC_W-1:0]       alu_control;
  logic [WIDTH-1:0]       alu_data1;
  logic [WIDTH-1:0]       alu_data2;
  logic [2*WIDTH-1:0]     alu_result;

  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     out_result;
  logic [OPC_W-1:0]       out_control;

  // Issue-stage view
  modport slave (
    input  in_valid, in_control, in_a, in_b, alu_result, out_ready,
    output in_ready, alu_control, alu_data1, alu_data2,
           out_valid, out_result, out_control
  );

  // Environment view: producer, ALU and consumer
  modport master (
    output in_valid, in_control, in_a, in_b, alu_result, out_ready,
    input  in_ready, alu_control, alu_data1, alu_data2,
           out_valid, out_result, out_control
  );

endinterface

// File: rtl/alu_issue_ctrl_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with count, full and empty flags.
// Head entry is visible on o_data while not empty (first-word fall-through).
// Optional feature macro used by this slice: ALU_ISSUE_ERR_EN (not used here).
module alu_cmd_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [DW-1:0]                i_data,
  input  logic                         i_pop,
  output logic [DW-1:0]                o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Overflow/underflow are blocked here so a misbehaving caller cannot corrupt the count
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage is not reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU commands, drives the combinational ALU from
// registers for one cycle, then offers the registered result downstream.
// Optional feature macro: ALU_ISSUE_ERR_EN -- drops opcodes 5..7 at the input
// and pulses err for one cycle after each such handshake.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  alu_issue_if.slave                  bus,
`ifdef ALU_ISSUE_ERR_EN
  output logic                        err,
`endif
  output state_t                      o_dbg_state,
  output logic [$clog2(DEPTH+1)-1:0]  o_dbg_count
);

  localparam int DW = OPC_W + 2*WIDTH;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_pop;
  logic                 w_capture;
  logic                 w_hs;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic [DW-1:0]        w_head;

  logic [OPC_W-1:0]     r_alu_control;
  logic [WIDTH-1:0]     r_alu_data1;
  logic [WIDTH-1:0]     r_alu_data2;
  logic [2*WIDTH-1:0]   r_out_result;
  logic [OPC_W-1:0]     r_out_control;

  // in_ready follows FIFO occupancy only
  assign bus.in_ready = !w_full;
  assign w_hs         = bus.in_valid && bus.in_ready;

`ifdef ALU_ISSUE_ERR_EN
  logic r_err;
  // Illegal opcodes are accepted but never enter the FIFO
  assign w_push = w_hs && is_legal(bus.in_control);
  assign err    = r_err;

  // One-cycle error pulse following each illegal handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_hs && !is_legal(bus.in_control);
  end
`else
  assign w_push = w_hs;
`endif

  alu_cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({bus.in_control, bus.in_a, bus.in_b}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_dbg_count)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next state plus pop/capture strobes
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_next_state = EXEC;
          w_pop        = 1'b1;
        end
      end
      EXEC: begin
        w_next_state = HOLD;
        w_capture    = 1'b1;
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (!w_empty) begin
            w_next_state = EXEC;
            w_pop        = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ALU operand registers change only when a command is popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_control <= '0;
      r_alu_data1   <= '0;
      r_alu_data2   <= '0;
    end else if (w_pop) begin
      r_alu_control <= w_head[DW-1 -: OPC_W];
      r_alu_data1   <= w_head[2*WIDTH-1 -: WIDTH];
      r_alu_data2   <= w_head[WIDTH-1:0];
    end
  end

  // Result capture at the end of the EXEC cycle; held stable through HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_result  <= '0;
      r_out_control <= '0;
    end else if (w_capture) begin
      r_out_result  <= bus.alu_result;
      r_out_control <= r_alu_control;
    end
  end

  assign bus.alu_control = r_alu_control;
  assign bus.alu_data1   = r_alu_data1;
  assign bus.alu_data2   = r_alu_data2;
  assign bus.out_result  = r_out_result;
  assign bus.out_control = r_out_control;
  assign bus.out_valid   = (r_state == HOLD);
  assign o_dbg_state     = r_state;

endmodule
